// File: rtl/de4_qsys_nios2_qsys_mul_issue_wb.sv
`default_nettype none
// ============================================================================
// Module      : de4_qsys_nios2_qsys_mul_issue_wb
// Description : Issue/writeback sequencer for the 2-stage registered
//               32x32->64 multiply cell. Accepts MUL/MULXSS/MULXSU/MULXUU
//               requests, drives cell operands, sign controls and stage
//               enables, tracks in-flight ops with their destination tags
//               and returns the low or high product word for writeback.
//               Build option NIOS2_MUL_WB_REG_EN adds a registered
//               writeback stage (one extra edge of latency, 3 ops in flight).
// Revision    : 1.0 - initial release
// ============================================================================
module de4_qsys_nios2_qsys_mul_issue_wb #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_src1,
    input  logic [31:0]      req_src2,
    input  logic [TAG_W-1:0] req_tag,

    output logic [31:0]      mc_src1,
    output logic [31:0]      mc_src2,
    output logic             mc_src1_signed,
    output logic             mc_src2_signed,
    output logic             mc_m_en,
    output logic             mc_a_en,
    input  logic [63:0]      mc_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,

    output logic             busy
);

    // Opcode encoding of req_op
    localparam logic [1:0] c_OP_MUL    = 2'd0;
    localparam logic [1:0] c_OP_MULXSS = 2'd1;
    localparam logic [1:0] c_OP_MULXSU = 2'd2;
    localparam logic [1:0] c_OP_MULXUU = 2'd3;

    // M stage: op currently held in the cell input registers
    logic             r_v_m;
    logic [1:0]       r_op_m;
    logic [TAG_W-1:0] r_tag_m;

    // A stage: op whose product sits in the cell output register
    logic             r_v_a;
    logic [1:0]       r_op_a;
    logic [TAG_W-1:0] r_tag_a;

    logic             w_a_en;
    logic             w_m_en;
    logic             w_accept;
    logic [31:0]      w_sel_word;

    // Operands go straight to the cell; it registers them itself under M_en.
    assign mc_src1 = req_src1;
    assign mc_src2 = req_src2;

    // Sign controls decoded from the incoming opcode every cycle, valid or not.
    // MUL only uses the low word, which does not depend on operand signedness.
    always_comb begin
        mc_src1_signed = 1'b0;
        mc_src2_signed = 1'b0;
        case (req_op)
            c_OP_MUL: begin
                mc_src1_signed = 1'b0;
                mc_src2_signed = 1'b0;
            end
            c_OP_MULXSS: begin
                mc_src1_signed = 1'b1;
                mc_src2_signed = 1'b1;
            end
            c_OP_MULXSU: begin
                mc_src1_signed = 1'b1;
                mc_src2_signed = 1'b0;
            end
            c_OP_MULXUU: begin
                mc_src1_signed = 1'b0;
                mc_src2_signed = 1'b0;
            end
        endcase
    end

    // Word select for the op leaving the cell: MUL takes bits 31:0, the
    // MULX* family takes bits 63:32.
    assign w_sel_word = (r_op_a == c_OP_MUL) ? mc_result[31:0] : mc_result[63:32];

`ifdef NIOS2_MUL_WB_REG_EN
    // W stage: registered writeback word
    logic             r_v_w;
    logic [31:0]      r_data_w;
    logic [TAG_W-1:0] r_tag_w;
    logic             w_w_en;

    // W advances when empty or being drained; A advances when it can move into W.
    assign w_w_en = !r_v_w || rsp_ready;
    assign w_a_en = !r_v_a || w_w_en;

    // Writeback register: captures the selected product word and its tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v_w    <= 1'b0;
            r_data_w <= 32'd0;
            r_tag_w  <= '0;
        end else if (flush) begin
            r_v_w    <= 1'b0;
        end else if (w_w_en) begin
            r_v_w    <= r_v_a;
            r_data_w <= w_sel_word;
            r_tag_w  <= r_tag_a;
        end
    end

    assign rsp_valid = r_v_w;
    assign rsp_data  = r_data_w;
    assign rsp_tag   = r_tag_w;
    assign busy      = r_v_m | r_v_a | r_v_w;
`else
    // A advances when empty or when its product is being consumed.
    assign w_a_en    = !r_v_a || rsp_ready;

    assign rsp_valid = r_v_a;
    assign rsp_data  = w_sel_word;
    assign rsp_tag   = r_tag_a;
    assign busy      = r_v_m | r_v_a;
`endif

    // M advances when empty or when A can take its op; a stalled pipeline
    // freezes the cell registers in lockstep through these enables.
    assign w_m_en    = !r_v_m || w_a_en;
    assign req_ready = w_m_en && !flush;
    assign w_accept  = req_valid && req_ready;

    assign mc_m_en   = w_m_en;
    assign mc_a_en   = w_a_en;

    // M stage tracking: load a new op (or a bubble) whenever the cell inputs load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v_m   <= 1'b0;
            r_op_m  <= 2'd0;
            r_tag_m <= '0;
        end else if (flush) begin
            r_v_m   <= 1'b0;
        end else if (w_m_en) begin
            r_v_m   <= w_accept;
            r_op_m  <= req_op;
            r_tag_m <= req_tag;
        end
    end

    // A stage tracking: follows the cell output register enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v_a   <= 1'b0;
            r_op_a  <= 2'd0;
            r_tag_a <= '0;
        end else if (flush) begin
            r_v_a   <= 1'b0;
        end else if (w_a_en) begin
            r_v_a   <= r_v_m;
            r_op_a  <= r_op_m;
            r_tag_a <= r_tag_m;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_de4_qsys_nios2_qsys_mul_issue_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_de4_qsys_nios2_qsys_mul_issue_wb
// Description : Self-checking bench for the multiply issue/writeback
//               sequencer. A behavioural 2-stage multiply cell sits behind
//               the DUT; a queue-based reference model predicts every
//               writeback word and tag from the accepted requests.
//               Honours NIOS2_MUL_WB_REG_EN (expected latency/depth).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_de4_qsys_nios2_qsys_mul_issue_wb;

    localparam int TAG_W = 5;
`ifdef NIOS2_MUL_WB_REG_EN
    localparam int LAT   = 3;
    localparam int DEPTH = 3;
`else
    localparam int LAT   = 2;
    localparam int DEPTH = 2;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_src1;
    logic [31:0]      req_src2;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      mc_src1;
    logic [31:0]      mc_src2;
    logic             mc_src1_signed;
    logic             mc_src2_signed;
    logic             mc_m_en;
    logic             mc_a_en;
    logic [63:0]      mc_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    de4_qsys_nios2_qsys_mul_issue_wb #(.TAG_W(TAG_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_src1       (req_src1),
        .req_src2       (req_src2),
        .req_tag        (req_tag),
        .mc_src1        (mc_src1),
        .mc_src2        (mc_src2),
        .mc_src1_signed (mc_src1_signed),
        .mc_src2_signed (mc_src2_signed),
        .mc_m_en        (mc_m_en),
        .mc_a_en        (mc_a_en),
        .mc_result      (mc_result),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_tag        (rsp_tag),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Extend a 32-bit operand to 64 bits as signed or unsigned.
    function automatic logic [63:0] ext64(input logic [31:0] v, input logic s);
        return s ? {{32{v[31]}}, v} : {32'd0, v};
    endfunction

    // Architectural result: low word for MUL, high word of the product with
    // the operand signedness the MULX variant names.
    function automatic logic [31:0] ref_word(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd0:    p = {32'd0, a} * {32'd0, b};
            2'd1:    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'd2:    p = {{32{a[31]}}, a} * {32'd0, b};
            default: p = {32'd0, a} * {32'd0, b};
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Behavioural multiply cell: input regs under M_en, product reg under A_en.
    logic [31:0] cell_a, cell_b;
    logic        cell_sa, cell_sb;
    always @(posedge clk) begin
        if (mc_m_en) begin
            cell_a  <= mc_src1;
            cell_b  <= mc_src2;
            cell_sa <= mc_src1_signed;
            cell_sb <= mc_src2_signed;
        end
        if (mc_a_en)
            mc_result <= ext64(cell_a, cell_sa) * ext64(cell_b, cell_sb);
    end

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] got_q[$];

    // Reference model: evaluated mid-cycle, describing the handshakes of the
    // coming edge. Queue holds every accepted op not yet written back.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            check("busy", 64'(busy), 64'(exp_q.size() != 0));
            check("occupancy", 64'(exp_q.size() <= DEPTH), 64'd1);
            if (rsp_valid)
                check("rsp_owner", 64'(exp_q.size() != 0), 64'd1);
            if (flush) begin
                check("ready_in_flush", 64'(req_ready), 64'd0);
                exp_q.delete();
            end else begin
                if (rsp_ready)
                    check("full_rate_ready", 64'(req_ready), 64'd1);
                if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    got_q.push_back(rsp_data);
                end
                if (req_valid && req_ready) begin
                    exp_t n;
                    n.data = ref_word(req_op, req_src1, req_src2);
                    n.tag  = req_tag;
                    exp_q.push_back(n);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        req_tag   = t;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++)
            step();
        step();
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Watchdog: the bench must always end on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        logic saw_stall;
        logic [31:0] corner [4];
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;

        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_src1  = 32'd0;
        req_src2  = 32'd0;
        req_tag   = '0;
        rsp_ready = 1'b1;

        // 1: reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_m_en", 64'(mc_m_en), 64'd1);
        check("rst_a_en", 64'(mc_a_en), 64'd1);
        reset_n = 1'b1;
        step();

        // 2: single MUL, latency check
        got_q.delete();
        drive(2'd0, 32'hFFFF_FFFF, 32'h2, TAG_W'(7));
        step();                      // accept edge
        req_valid = 1'b0;
        for (int i = 1; i < LAT - 1; i++) begin
            check("lat_early", 64'(rsp_valid), 64'd0);
            step();
        end
        check("lat_early", 64'(rsp_valid), 64'd0);
        step();
        check("lat_valid", 64'(rsp_valid), 64'd1);
        check("lat_data", 64'(rsp_data), 64'hFFFF_FFFE);
        check("lat_tag", 64'(rsp_tag), 64'd7);
        drain("t2_drain");

        // 3: MULXSS/MULXSU/MULXUU back to back on all-ones operands
        got_q.delete();
        for (int i = 1; i <= 3; i++) begin
            drive(2'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, TAG_W'(i));
            step();
        end
        req_valid = 1'b0;
        drain("t3_drain");
        check("t3_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            check("t3_mulxss", 64'(got_q[0]), 64'h0000_0000);
            check("t3_mulxsu", 64'(got_q[1]), 64'hFFFF_FFFF);
            check("t3_mulxuu", 64'(got_q[2]), 64'hFFFF_FFFE);
        end

        // 4: stream 8 requests with 4 stalled writeback cycles
        got_q.delete();
        idx = 0;
        cyc = 0;
        saw_stall = 1'b0;
        while (idx < 8 && cyc < 200) begin
            drive(2'(idx % 4), $urandom, $urandom, TAG_W'(idx + 8));
            rsp_ready = (cyc >= 4);
            @(negedge clk);
            if (req_ready) idx++;
            else           saw_stall = 1'b1;
            step();
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("t4_all_sent", 64'(idx), 64'd8);
        check("t4_backpressure", 64'(saw_stall), 64'd1);
        drain("t4_drain");
        check("t4_count", 64'(got_q.size()), 64'd8);

        // 5: flush with two ops in flight and a request pending
        got_q.delete();
        rsp_ready = 1'b0;
        drive(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, TAG_W'(1));
        step();
        drive(2'd0, 32'h7, 32'h9, TAG_W'(2));
        step();
        drive(2'd3, 32'h5, 32'h6, TAG_W'(3));
        flush = 1'b1;
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) step();
        check("t5_no_rsp", 64'(got_q.size()), 64'd0);
        check("t5_idle", 64'(busy), 64'd0);
        drive(2'd0, 32'd3, 32'd5, TAG_W'(4));
        step();
        req_valid = 1'b0;
        drain("t5_drain");
        check("t5_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1)
            check("t5_after_flush", 64'(got_q[0]), 64'hF);

        // 6: async reset while a response is stalled
        got_q.delete();
        rsp_ready = 1'b0;
        drive(2'd3, 32'h0001_0000, 32'h0001_0000, TAG_W'(9));
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++)
            step();
        check("t6_stalled_valid", 64'(rsp_valid), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_req_ready", 64'(req_ready), 64'd1);
        step();
        #2;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) step();
        check("t6_no_stale", 64'(got_q.size()), 64'd0);
        check("t6_rsp_valid", 64'(rsp_valid), 64'd0);

        // Randomized traffic with backpressure and occasional flushes
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 2'($urandom_range(0, 3));
            req_src1  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            req_src2  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            req_tag   = TAG_W'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            step();
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        drain("rand_drain");
        check("rand_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
